// File: rtl/ram_read_responder_if.sv
// Request/response handshake bus between the instruction-queue initiator
// (master) and the RAM read responder (slave).
interface ram_read_responder_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int TAG_W  = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_address;
    logic [TAG_W-1:0]  req_tag;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_value;
    logic [TAG_W-1:0]  resp_tag;

    modport master (
        output req_valid, req_address, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_value, resp_tag
    );

    modport slave (
        input  req_valid, req_address, req_tag, resp_ready,
        output req_ready, resp_valid, resp_value, resp_tag
    );
endinterface

// File: rtl/ram_read_responder.sv
// In-order tagged read responder: request FIFO feeding a block-RAM read port and a
// registered valid/ready response stage. READ_RESP_STATS_EN adds served_count_o.
module ram_read_responder #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int TAG_W  = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    ram_read_responder_if.slave      bus,
    output logic [$clog2(DEPTH):0]   pending_o,
    output logic [ADDR_W-1:0]        ram_read_address_o,
    input  logic [DATA_W-1:0]        ram_read_value_i
`ifdef READ_RESP_STATS_EN
    ,
    output logic [15:0]              served_count_o
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_mem_q [DEPTH];
    logic [TAG_W-1:0]  tag_mem_q  [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_value_q, resp_value_d;
    logic [TAG_W-1:0]  resp_tag_q, resp_tag_d;

    logic full, empty, push, load, hs;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = bus.req_valid && !full;
    assign load  = !empty && (!resp_valid_q || bus.resp_ready);
    assign hs    = resp_valid_q && bus.resp_ready;

    // RAM address comes only from registered FIFO state, so no req_* to RAM path.
    assign ram_read_address_o = empty ? '0 : addr_mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q + CNT_W'(push) - CNT_W'(load);
        resp_valid_d = resp_valid_q;
        resp_value_d = resp_value_q;
        resp_tag_d   = resp_tag_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (load) begin
            rd_ptr_d     = rd_ptr_q + PTR_W'(1);
            resp_valid_d = 1'b1;
            resp_value_d = ram_read_value_i;
            resp_tag_d   = tag_mem_q[rd_ptr_q];
        end else if (hs) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_value_q <= '0;
            resp_tag_q   <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            resp_valid_q <= resp_valid_d;
            resp_value_q <= resp_value_d;
            resp_tag_q   <= resp_tag_d;
        end
    end

    // Storage needs no reset: occupancy decides what is live.
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_mem_q[wr_ptr_q] <= bus.req_address;
            tag_mem_q[wr_ptr_q]  <= bus.req_tag;
        end
    end

    assign bus.req_ready  = !full;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_value = resp_value_q;
    assign bus.resp_tag   = resp_tag_q;
    assign pending_o      = count_q;

`ifdef READ_RESP_STATS_EN
    logic [15:0] served_q;
    always_ff @(posedge clk_i) begin
        if (rst_i)   served_q <= '0;
        else if (hs) served_q <= served_q + 16'd1;
    end
    assign served_count_o = served_q;
`endif
endmodule
